// File: rtl/nios2_debug_pkg.sv
// nios2_debug_pkg: IR opcodes, jdo field offsets and helpers for the Nios II debug command stage
package nios2_debug_pkg;
  typedef enum logic [1:0] {
    IR_OCIMEM = 2'd0,
    IR_RSVD   = 2'd1,
    IR_BREAK  = 2'd2,
    IR_TRACE  = 2'd3
  } ir_op_e;
  localparam int ACT_OFS = 1;
  localparam int SUBB_OFS = 2;
  localparam int CH_OFS = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// nios2_dbg_sync_edge: multi-flop synchroniser with rising-edge detect, all flops reset to 1
module nios2_dbg_sync_edge
  import nios2_debug_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] sync_q;
  logic hist;
  always_ff @(posedge clk)
    if (reset) begin
      sync_q <= '1;
      hist <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist <= sync_q[STAGES-1];
    end
  assign rise = sync_q[STAGES-1] & ~hist;
endmodule

// File: rtl/nios2_debug_cmd_sync.sv
// nios2_debug_cmd_sync: sysclk-side JTAG debug command capture and decode; DBG_CMD_PARITY_EN enables jdo even-parity checking
module nios2_debug_cmd_sync
  import nios2_debug_pkg::*;
#(
  parameter int SR_W = 38,
  parameter int IR_W = 2,
  parameter int NUM_BRK = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vs_udr,
  input  logic               vs_uir,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [SR_W-1:0]    sr,
  input  logic               cmd_ready,
  output logic [SR_W-1:0]    jdo,
  output logic               cmd_pending,
  output logic               take_action_ocimem_a,
  output logic               take_no_action_ocimem_a,
  output logic               take_action_ocimem_b,
  output logic [NUM_BRK-1:0] take_action_brk,
  output logic [NUM_BRK-1:0] take_no_action_brk,
  output logic               take_action_tracectrl,
  output logic               overrun
`ifdef DBG_CMD_PARITY_EN
  ,
  output logic               parity_err
`endif
);
  localparam int CH_W = clog2(NUM_BRK) < 1 ? 1 : clog2(NUM_BRK);
  localparam logic [NUM_BRK-1:0] BRK_ONE = NUM_BRK'(1);
  logic udr_rise, uir_rise, cmd_bad, fire, act, subb, ch_ok;
  logic [IR_W-1:0] ir_q, cmd_ir;
  logic [CH_W-1:0] ch;
  ir_op_e op;
  nios2_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_udr (
    .clk(clk),
    .reset(reset),
    .d(vs_udr),
    .rise(udr_rise)
  );
  nios2_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_uir (
    .clk(clk),
    .reset(reset),
    .d(vs_uir),
    .rise(uir_rise)
  );
  always_ff @(posedge clk)
    if (reset) begin
      jdo <= '0;
      ir_q <= '0;
      cmd_ir <= '0;
      cmd_pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (uir_rise) ir_q <= ir_in;
      if (udr_rise && !cmd_pending) begin
        jdo <= sr;
        cmd_ir <= ir_q;
        cmd_pending <= 1'b1;
      end else if (cmd_pending && cmd_ready) cmd_pending <= 1'b0;
      if (udr_rise && cmd_pending) overrun <= 1'b1;
    end
`ifdef DBG_CMD_PARITY_EN
  always_ff @(posedge clk)
    if (reset) begin
      cmd_bad <= 1'b0;
      parity_err <= 1'b0;
    end else if (udr_rise && !cmd_pending) begin
      cmd_bad <= ^sr;
      if (^sr) parity_err <= 1'b1;
    end
`else
  assign cmd_bad = 1'b0;
`endif
  always_comb begin
    act = jdo[SR_W-ACT_OFS];
    subb = jdo[SR_W-SUBB_OFS];
    ch = jdo[SR_W-CH_OFS -: CH_W];
    op = ir_op_e'(cmd_ir[1:0]);
    fire = cmd_pending && cmd_ready && !cmd_bad && ((cmd_ir >> 2) == '0);
    ch_ok = 32'(ch) < NUM_BRK;
    take_action_ocimem_a = fire && op == IR_OCIMEM && act;
    take_no_action_ocimem_a = fire && op == IR_OCIMEM && !act;
    take_action_ocimem_b = fire && op == IR_OCIMEM && subb;
    take_action_tracectrl = fire && op == IR_TRACE && act;
    take_action_brk = (fire && op == IR_BREAK && ch_ok && act) ? BRK_ONE << ch : '0;
    take_no_action_brk = (fire && op == IR_BREAK && ch_ok && !act) ? BRK_ONE << ch : '0;
  end
endmodule
